// File: rtl/enc_seq_pkg.sv
// enc_seq shared types, default widths and priority helper.
// Order selected by ENC_SEQ_LSB_FIRST_EN (defined: ascending).
package enc_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int OUT_SIZE_DEF = 4;
    localparam int MAX_IN       = 256;

    // Only the low n bits of v take part; upper bits are ignored.
    function automatic int prio_idx(
        input logic [MAX_IN-1:0] v,
        input int                n,
        input bit                lsb_first
    );
        int idx;
        idx = 0;
        if (lsb_first) begin
            for (int i = MAX_IN - 1; i >= 0; i--)
                if (i < n && v[i]) idx = i;
        end else begin
            for (int i = 0; i < MAX_IN; i++)
                if (i < n && v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/enc_seq_if.sv
// enc_seq request/index handshake bundle.
// slave = encoder side, master = producer/consumer side.
interface enc_seq_if
    import enc_seq_pkg::*;
#(
    parameter int OUT_SIZE = OUT_SIZE_DEF,
    parameter int IN_SIZE  = 1 << OUT_SIZE
);
    logic [IN_SIZE-1:0]  in;
    logic                in_valid;
    logic                in_ready;
    logic [OUT_SIZE-1:0] out;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;

    modport slave (
        input  in, in_valid, out_ready,
        output in_ready, out, out_valid, out_last
    );

    modport master (
        output in, in_valid, out_ready,
        input  in_ready, out, out_valid, out_last
    );
endinterface

// File: rtl/enc_prio.sv
// Combinational priority encoder with nonzero and single-bit flags.
// ENC_SEQ_LSB_FIRST_EN picks lowest index, else highest.
module enc_prio
    import enc_seq_pkg::*;
#(
    parameter int OUT_SIZE = OUT_SIZE_DEF,
    parameter int IN_SIZE  = 1 << OUT_SIZE
) (
    input  logic [IN_SIZE-1:0]  vec,
    output logic [OUT_SIZE-1:0] idx,
    output logic                nz,
    output logic                one
);
`ifdef ENC_SEQ_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    logic [IN_SIZE-1:0] vec_m1;

    assign vec_m1 = vec - IN_SIZE'(1);
    assign nz     = |vec;
    assign one    = nz && ((vec & vec_m1) == '0);
    assign idx    = OUT_SIZE'(prio_idx(MAX_IN'(vec), IN_SIZE, LSB_FIRST));
endmodule

// File: rtl/enc_seq.sv
// Sequential multi-hot encoder: drains a vector into binary indices.
// Build option ENC_SEQ_LSB_FIRST_EN selects ascending order.
module enc_seq
    import enc_seq_pkg::*;
#(
    parameter int OUT_SIZE = OUT_SIZE_DEF,
    parameter int IN_SIZE  = 1 << OUT_SIZE
) (
    input logic        clock,
    input logic        reset_n,
    input logic        enable,
    enc_seq_if.slave   bus
);
    state_t              state;
    logic [IN_SIZE-1:0]  pending;
    logic [IN_SIZE-1:0]  vec;
    logic [IN_SIZE-1:0]  vec_clr;
    logic [OUT_SIZE-1:0] idx;
    logic                nz;
    logic                one;
    logic [OUT_SIZE-1:0] out_q;
    logic                valid_q;
    logic                last_q;

    // One encoder serves both capture and drain.
    assign vec     = (state == IDLE) ? bus.in : pending;
    assign vec_clr = vec & ~(IN_SIZE'(1) << idx);

    enc_prio #(
        .OUT_SIZE (OUT_SIZE),
        .IN_SIZE  (IN_SIZE)
    ) u_prio (
        .vec (vec),
        .idx (idx),
        .nz  (nz),
        .one (one)
    );

    assign bus.in_ready  = (state == IDLE) && enable && reset_n;
    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pending <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready && nz) begin
                        pending <= vec_clr;
                        out_q   <= idx;
                        valid_q <= 1'b1;
                        last_q  <= one;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (!enable) begin
                        state   <= IDLE;
                        pending <= '0;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                    end else if (valid_q && bus.out_ready) begin
                        if (last_q) begin
                            state   <= IDLE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                        end else begin
                            out_q   <= idx;
                            pending <= vec_clr;
                            last_q  <= one;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_enc_seq.sv
// Self-checking bench for enc_seq: vector table, random drains, corner cases.
// Expectations follow ENC_SEQ_LSB_FIRST_EN when defined.
module tb_enc_seq;
    import enc_seq_pkg::*;

    logic clock;
    logic reset_n;
    logic enable;
    int   n_cmp;
    int   n_err;

    enc_seq_if #(.OUT_SIZE(4)) bus ();

    enc_seq #(.OUT_SIZE(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] vin;
        int          cnt;
        logic [3:0]  first_hi;
        logic [3:0]  first_lo;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference order: indices of set bits, highest or lowest first.
    task automatic model(input logic [15:0] v, output logic [3:0] q[$]);
        q = {};
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
`ifdef ENC_SEQ_LSB_FIRST_EN
                q.push_back(4'(i));
`else
                q.push_front(4'(i));
`endif
            end
        end
    endtask

    // Called at a negedge with the DUT idle.
    task automatic run_vec(input logic [15:0] v, input int pct,
                           output int cyc, output logic [3:0] first);
        logic [3:0] q[$];
        model(v, q);
        bus.in        = v;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        #1;
        chk("cap_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.in       = '0;
        first = bus.out;
        cyc   = 0;
        if (q.size() == 0) begin
            chk("zero_valid", 32'(bus.out_valid), 32'd0);
        end
        while (q.size() > 0 && cyc < 200) begin
            chk("valid", 32'(bus.out_valid), 32'd1);
            chk("idx", 32'(bus.out), 32'(q[0]));
            chk("last", 32'(bus.out_last), 32'(q.size() == 1));
            chk("busy", 32'(bus.in_ready), 32'd0);
            bus.out_ready = ($urandom_range(99) < pct);
            if (bus.out_ready) void'(q.pop_front());
            @(negedge clock);
            cyc++;
        end
        bus.out_ready = 1'b0;
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
        chk("done_valid", 32'(bus.out_valid), 32'd0);
        chk("done_ready", 32'(bus.in_ready), 32'd1);
    endtask

    vec_t       tbl[6];
    int         cyc;
    logic [3:0] first;
    logic [3:0] q[$];
    logic [3:0] exp_first;

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n       = 1'b0;
        enable        = 1'b1;
        bus.in        = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        tbl[0] = '{16'h8421, 4,  4'hF, 4'h0};
        tbl[1] = '{16'h0003, 2,  4'h1, 4'h0};
        tbl[2] = '{16'h8000, 1,  4'hF, 4'hF};
        tbl[3] = '{16'h0001, 1,  4'h0, 4'h0};
        tbl[4] = '{16'hFFFF, 16, 4'hF, 4'h0};
        tbl[5] = '{16'h0000, 0,  4'h0, 4'h0};

        #12;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out", 32'(bus.out), 32'd0);
        chk("rst_last", 32'(bus.out_last), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 6; i++) begin
            run_vec(tbl[i].vin, 100, cyc, first);
            chk("tbl_cycles", 32'(cyc), 32'(tbl[i].cnt));
            if (tbl[i].cnt > 0) begin
`ifdef ENC_SEQ_LSB_FIRST_EN
                chk("tbl_first", 32'(first), 32'(tbl[i].first_lo));
`else
                chk("tbl_first", 32'(first), 32'(tbl[i].first_hi));
`endif
            end
            @(negedge clock);
        end

        // Backpressure: ready pattern 0,0,1,0,1 on 16'h0003.
`ifdef ENC_SEQ_LSB_FIRST_EN
        exp_first = 4'h0;
`else
        exp_first = 4'h1;
`endif
        bus.in = 16'h0003;
        bus.in_valid = 1'b1;
        @(negedge clock);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_idx", 32'(bus.out), 32'(i < 3 ? exp_first : ~exp_first & 4'h1));
            chk("bp_last", 32'(bus.out_last), 32'(i >= 3));
            bus.out_ready = (i == 2 || i == 4);
            @(negedge clock);
        end
        bus.out_ready = 1'b0;
        chk("bp_done", 32'(bus.out_valid), 32'd0);

        // Zero vector held valid for several cycles.
        bus.in = '0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("zero_hold_valid", 32'(bus.out_valid), 32'd0);
            chk("zero_hold_ready", 32'(bus.in_ready), 32'd1);
        end
        bus.in_valid = 1'b0;

        // Enable abort after three handshakes.
        model(16'hFFFF, q);
        bus.in = 16'hFFFF;
        bus.in_valid = 1'b1;
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("abort_idx", 32'(bus.out), 32'(q[i]));
            @(negedge clock);
        end
        enable = 1'b0;
        @(negedge clock);
        chk("abort_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_ready_off", 32'(bus.in_ready), 32'd0);
        repeat (2) @(negedge clock);
        chk("abort_stay", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
        enable = 1'b1;
        #1;
        chk("abort_ready_on", 32'(bus.in_ready), 32'd1);
        @(negedge clock);

        // Reset in the middle of a scan.
        bus.in = 16'h8421;
        bus.in_valid = 1'b1;
        @(negedge clock);
        bus.in_valid = 1'b0;
        chk("mid_valid_pre", 32'(bus.out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_out", 32'(bus.out), 32'd0);
        chk("mid_last", 32'(bus.out_last), 32'd0);
        chk("mid_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("mid_release", 32'(bus.in_ready), 32'd1);
        @(negedge clock);

        // Random vectors with random backpressure.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            if (i % 3 == 0) v = v & 16'($urandom) & 16'($urandom);
            run_vec(v, $urandom_range(100, 30), cyc, first);
            @(negedge clock);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
